// File: rtl/sys_ctrl_tx.sv
// Response serializer: captures register-read and ALU results and streams them
// bytewise to a UART transmitter. Define SYS_CTRL_TX_FRAME_EN to prefix each response with a header byte.
module sys_ctrl_tx (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  RdData,
   input  logic        RdData_Valid,
   input  logic [15:0] ALU_OUT,
   input  logic        OUT_Valid,
   input  logic        Busy,
   output logic [7:0]  TX_P_DATA,
   output logic        TX_D_VALID
);

`ifdef SYS_CTRL_TX_FRAME_EN
   localparam int NB = 3;
`else
   localparam int NB = 2;
`endif

   typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_HI, WAIT_LO} state_t;

   state_t             state, nxt;
   logic               rd_pend, alu_pend;
   logic [7:0]         rd_hold;
   logic [15:0]        alu_hold;
   logic [NB-1:0][7:0] bytes;
   logic [1:0]         nbytes, idx;
   logic [3:0]         guard;
   logic               go_load, sel_rd, sel_alu, dispatch;
   logic [7:0]         cur_byte;

   // ---------------- state register ----------------
   always_ff @(posedge CLK) begin
      if (!RST) state <= IDLE;
      else      state <= nxt;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (rd_pend || alu_pend) nxt = LOAD;
         LOAD:    nxt = STROBE;
         STROBE:  if (!Busy) nxt = WAIT_HI;
         // guard == 15 marks the 16th idle cycle without a Busy handshake
         WAIT_HI: if (Busy || guard == 4'd15) nxt = WAIT_LO;
         WAIT_LO: if (!Busy) nxt = (idx < nbytes) ? STROBE : IDLE;
         default: nxt = IDLE;
      endcase
   end

   // ---------------- output / control decode ----------------
   always_comb begin
      go_load  = (state == IDLE) && (rd_pend || alu_pend);
      sel_rd   = go_load && rd_pend;
      sel_alu  = go_load && !rd_pend;
      dispatch = (state == STROBE) && !Busy;
`ifdef SYS_CTRL_TX_FRAME_EN
      cur_byte = bytes[idx];
`else
      cur_byte = bytes[idx[0]];
`endif
   end

   // Capture wins over the clear on LOAD entry, so a same-cycle strobe is kept.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         rd_pend  <= 1'b0;
         rd_hold  <= 8'h00;
         alu_pend <= 1'b0;
         alu_hold <= 16'h0000;
      end else begin
         if (RdData_Valid && (!rd_pend || sel_rd)) begin
            rd_pend <= 1'b1;
            rd_hold <= RdData;
         end else if (sel_rd) begin
            rd_pend <= 1'b0;
         end
         if (OUT_Valid && (!alu_pend || sel_alu)) begin
            alu_pend <= 1'b1;
            alu_hold <= ALU_OUT;
         end else if (sel_alu) begin
            alu_pend <= 1'b0;
         end
      end
   end

   // Byte queue is snapshotted from the holding register on LOAD entry.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         bytes  <= '0;
         nbytes <= 2'd0;
         idx    <= 2'd0;
      end else if (go_load) begin
         idx <= 2'd0;
`ifdef SYS_CTRL_TX_FRAME_EN
         if (rd_pend) begin
            bytes  <= {8'h00, rd_hold, 8'hBB};
            nbytes <= 2'd2;
         end else begin
            bytes  <= {alu_hold[15:8], alu_hold[7:0], 8'hCC};
            nbytes <= 2'd3;
         end
`else
         if (rd_pend) begin
            bytes  <= {8'h00, rd_hold};
            nbytes <= 2'd1;
         end else begin
            bytes  <= {alu_hold[15:8], alu_hold[7:0]};
            nbytes <= 2'd2;
         end
`endif
      end else if (dispatch) begin
         idx <= idx + 2'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST)                          guard <= 4'd0;
      else if (state == WAIT_HI && !Busy) guard <= guard + 4'd1;
      else                               guard <= 4'd0;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         TX_P_DATA  <= 8'h00;
         TX_D_VALID <= 1'b0;
      end else begin
         TX_D_VALID <= dispatch;
         if (dispatch) TX_P_DATA <= cur_byte;
      end
   end

endmodule

// File: tb/tb_sys_ctrl_tx.sv
// Bench for sys_ctrl_tx: directed scenarios plus randomized responses,
// checked against a byte-list reference model and a Busy-driven UART stand-in.
module tb_sys_ctrl_tx;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [7:0]  RdData = 8'h00;
   logic        RdData_Valid = 1'b0;
   logic [15:0] ALU_OUT = 16'h0000;
   logic        OUT_Valid = 1'b0;
   logic        Busy = 1'b0;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VALID;

   sys_ctrl_tx dut (
      .CLK(CLK), .RST(RST), .RdData(RdData), .RdData_Valid(RdData_Valid),
      .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid), .Busy(Busy),
      .TX_P_DATA(TX_P_DATA), .TX_D_VALID(TX_D_VALID)
   );

   always #5 CLK = ~CLK;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         got_t[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // UART stand-in: mode 1 holds Busy high for blen cycles after each strobe
   int   bmode  = 0;
   logic bforce = 1'b0;
   int   blen   = 10;
   int   bcnt   = 0;
   always @(posedge CLK) begin
      #1;
      if (bmode == 1) begin
         if (TX_D_VALID) bcnt = blen;
         Busy = (bcnt > 0);
         if (bcnt > 0) bcnt--;
      end else begin
         bcnt = 0;
         Busy = bforce;
      end
   end

   // Byte monitor; a strobe must never be issued on an edge where Busy was high
   logic b_at_edge;
   always @(posedge CLK) begin
      b_at_edge = Busy;
      #1;
      cyc++;
      if (TX_D_VALID) begin
         got_q.push_back(TX_P_DATA);
         got_t.push_back(cyc);
         check("strobe_while_busy", {31'd0, b_at_edge}, 32'd0);
      end
   end

   // Reference model: the byte list each response must produce
   task automatic push_rd(input logic [7:0] d);
`ifdef SYS_CTRL_TX_FRAME_EN
      exp_q.push_back(8'hBB);
`endif
      exp_q.push_back(d);
   endtask

   task automatic push_alu(input logic [15:0] a);
`ifdef SYS_CTRL_TX_FRAME_EN
      exp_q.push_back(8'hCC);
`endif
      exp_q.push_back(a[7:0]);
      exp_q.push_back(a[15:8]);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   task automatic clr();
      exp_q.delete();
      got_q.delete();
      got_t.delete();
   endtask

   // Returns the edge index at which the strobe is sampled
   task automatic send(input logic rd, input logic [7:0] d, input logic alu,
                       input logic [15:0] a, output int n_edge);
      RdData = d; RdData_Valid = rd;
      ALU_OUT = a; OUT_Valid = alu;
      n_edge = cyc + 1;
      tick(1);
      RdData_Valid = 1'b0;
      OUT_Valid = 1'b0;
   endtask

   task automatic drain(input string tag, input int budget);
      int k = 0;
      while (got_q.size() < exp_q.size() && k < budget) begin
         tick(1);
         k++;
      end
      tick(30);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
   endtask

   function automatic int first_t();
      return (got_t.size() > 0) ? got_t[0] : -1;
   endfunction

   function automatic int last_gap();
      int s = got_t.size();
      return (s >= 2) ? got_t[s-1] - got_t[s-2] : -1;
   endfunction

   initial begin
      int n;
      int kind;
      logic [7:0]  rd_d;
      logic [15:0] alu_d;

      // Reset state
      RST = 1'b0;
      tick(3);
      check("reset_data",  {24'd0, TX_P_DATA}, 32'h00);
      check("reset_valid", {31'd0, TX_D_VALID}, 32'd0);
      RST = 1'b1;
      tick(2);

      // Read path
      bmode = 1; blen = 10;
      clr();
      push_rd(8'h3C);
      send(1'b1, 8'h3C, 1'b0, 16'h0, n);
      drain("read", 100);
`ifndef SYS_CTRL_TX_FRAME_EN
      check("read_latency", first_t(), n + 3);
`endif

      // ALU path: second strobe only after Busy has fallen
      clr();
      push_alu(16'hA55A);
      send(1'b0, 8'h00, 1'b1, 16'hA55A, n);
      drain("alu", 150);
`ifndef SYS_CTRL_TX_FRAME_EN
      check("alu_latency", first_t(), n + 3);
`endif
      check("alu_gap_after_busy", {31'd0, last_gap() > blen}, 32'd1);

      // Collision: read first, then ALU
      clr();
      push_rd(8'h11);
      push_alu(16'h2233);
      send(1'b1, 8'h11, 1'b1, 16'h2233, n);
      drain("collide", 200);

      // Strobe ignored while its flag is pending
      clr();
      bmode = 0; bforce = 1'b1;
      push_rd(8'h44);
      push_alu(16'h1234);
      send(1'b1, 8'h44, 1'b0, 16'h0, n);
      tick(5);
      send(1'b0, 8'h00, 1'b1, 16'h1234, n);
      tick(2);
      send(1'b0, 8'h00, 1'b1, 16'h9999, n);
      tick(2);
      bmode = 1; blen = 4;
      drain("pend_ignore", 200);

      // Lost handshake: Busy stays low
      clr();
      bmode = 0; bforce = 1'b0;
      push_alu(16'hBEEF);
      send(1'b0, 8'h00, 1'b1, 16'hBEEF, n);
      drain("lost_hs", 200);
      check("lost_hs_gap", {31'd0, last_gap() >= 17 && last_gap() <= 18}, 32'd1);
      // FSM back in IDLE: a fresh read sees normal latency
      clr();
      push_rd(8'h5E);
      send(1'b1, 8'h5E, 1'b0, 16'h0, n);
      drain("after_lost", 200);
`ifndef SYS_CTRL_TX_FRAME_EN
      check("after_lost_latency", first_t(), n + 3);
`endif

      // Reset mid-response abandons it
      clr();
      bmode = 1; blen = 10;
      send(1'b0, 8'h00, 1'b1, 16'h7788, n);
      for (int k = 0; k < 50 && got_q.size() < 1; k++) tick(1);
      tick(3);
      RST = 1'b0;
      tick(1);
      check("midrst_data",  {24'd0, TX_P_DATA}, 32'h00);
      check("midrst_valid", {31'd0, TX_D_VALID}, 32'd0);
      tick(1);
      RST = 1'b1;
      tick(40);
      check("midrst_nobytes", got_q.size(), 32'd1);
      check("midrst_hold",    {24'd0, TX_P_DATA}, 32'h00);

      // Randomized responses
      for (int it = 0; it < 25; it++) begin
         clr();
         kind  = $urandom_range(0, 2);
         blen  = $urandom_range(0, 12);
         rd_d  = 8'($urandom);
         alu_d = 16'($urandom);
         if (kind != 1) push_rd(rd_d);
         if (kind != 0) push_alu(alu_d);
         send(kind != 1, rd_d, kind != 0, alu_d, n);
         drain("rand", 400);
`ifndef SYS_CTRL_TX_FRAME_EN
         check("rand_latency", first_t(), n + 3);
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
